// File: rtl/piso_pkg.sv
// Shared types, limits and frame-length helpers for the PISO serializer.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  localparam int PISO_MAX_WIDTH = 32;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Bits on the wire per accepted word (data plus optional parity).
  function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Bits still held after bit 0 leaves directly from din on the accept edge.
  function automatic int shreg_len(input int width);
    return PARITY_EN ? width : width - 1;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Load/shift register for the PISO serializer: holds the not-yet-sent bits,
// counts bits of the current frame and flags the final one.
// With PISO_PARITY_EN the word's even parity rides in the extra MSB.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             next_bit,
  output logic             last
);

  localparam int FL  = frame_len(WIDTH);
  localparam int SRW = shreg_len(WIDTH);
  localparam int CW  = $clog2(WIDTH + 2);

  logic [SRW-1:0] shreg;
  logic [SRW-1:0] ld_val;
  logic [CW-1:0]  cnt;
  logic           last_r;

`ifdef PISO_PARITY_EN
  assign ld_val = {^din, din[WIDTH-1:1]};
`else
  assign ld_val = din[WIDTH-1:1];
`endif

  // Bit that goes onto the wire at the coming edge: din[0] on a load, else the register head.
  assign next_bit = load ? din[0] : shreg[0];
  assign last     = last_r;

  // Load a fresh word, advance one bit, or clear at end of frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      cnt    <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      shreg  <= ld_val;
      cnt    <= CW'(1);
      last_r <= 1'b0;
    end else if (shift) begin
      shreg  <= shreg >> 1;
      cnt    <= cnt + CW'(1);
      // Counter reaching FL-1 here means the bit being launched is the final one.
      last_r <= (cnt == CW'(FL - 1));
    end else if (clear) begin
      shreg  <= '0;
      cnt    <= '0;
      last_r <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a
// valid/ready handshake and sends it LSB first with frame markers.
// Back-to-back words stream with no idle cycle between frames.
// Optional feature: PISO_PARITY_EN appends an even-parity bit (frame = WIDTH+1).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             qout,
  output logic             qoutb,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  state_t state;
  logic   accept;
  logic   shift;
  logic   clear;
  logic   next_bit;
  logic   last;

  // Ready when idle, or on the final bit so the next word follows without a gap.
  assign din_ready = (state == IDLE) || last;
  assign accept    = din_valid && din_ready;
  assign shift     = (state == SHIFT) && !last;
  assign clear     = (state == SHIFT) && last && !accept;

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shift),
    .clear    (clear),
    .din      (din),
    .next_bit (next_bit),
    .last     (last)
  );

  // FSM and registered serial outputs; qout/qoutb always come from the same next-bit value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      qout       <= 1'b0;
      qoutb      <= 1'b1;
      sout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            qout       <= next_bit;
            qoutb      <= ~next_bit;
            sout_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last || accept) begin
            state      <= SHIFT;
            qout       <= next_bit;
            qoutb      <= ~next_bit;
            sout_valid <= 1'b1;
          end else begin
            state      <= IDLE;
            qout       <= 1'b0;
            qoutb      <= 1'b1;
            sout_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          qout       <= 1'b0;
          qoutb      <= 1'b1;
          sout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sout_last = last;
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based reference of the
// expected wire stream, checked every cycle, plus directed literal frames.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int WIDTH = 8;
  localparam int FL    = frame_len(WIDTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             din_ready, qout, qoutb, sout_valid, sout_last, busy;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .qout       (qout),
    .qoutb      (qoutb),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;

  // Reference: queue of bits still to appear on the wire, front = current cycle.
  typedef struct packed {logic b; logic l;} ent_t;
  ent_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    ent_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.b = w[i];
      e.l = (i == FL - 1);
      q.push_back(e);
    end
    if (FL > WIDTH) begin
      e.b = ^w;
      e.l = 1'b1;
      q.push_back(e);
    end
  endtask

  // Model advance on each edge: a word is taken when idle or on its predecessor's last bit.
  always @(posedge clk) begin
    logic rdy;
    if (rst) begin
      rdy = 1'b1;
      if (q.size() > 0) rdy = q[0].l;
      if (q.size() > 0) void'(q.pop_front());
      if (din_valid && rdy) begin
        push_frame(din);
        acc_cnt++;
      end
    end
  end

  always @(negedge rst) q.delete();

  function automatic logic [5:0] outs();
    return {qout, qoutb, sout_valid, sout_last, busy, din_ready};
  endfunction

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    if (q.size() == 0) exp_v = 6'b010001;
    else exp_v = {q[0].b, ~q[0].b, 1'b1, q[0].l, 1'b1, q[0].l};
    check("cycle_outputs", 32'(outs()), 32'(exp_v));
  end

  task automatic send(input logic [WIDTH-1:0] w, input bit hold);
    int start;
    bit got;
    start = acc_cnt;
    got = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (acc_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] cq, output logic [31:0] cl,
                         output logic [31:0] cv);
    cq = '0; cl = '0; cv = '0;
    for (int i = 0; i < n; i++) begin
      cq[i] = qout;
      cl[i] = sout_last;
      cv[i] = sout_valid;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] cq, cl, cv, cr;
    int start;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", 32'(outs()), 32'(6'b010001));
    rst = 1'b1;
    @(negedge clk);

    // Single word A5, nothing following
    send(8'hA5, 1'b0);
    capture(FL, cq, cl, cv);
    check("a5_bits", cq, 32'h0A5);
    check("a5_last", cl, 32'(1) << (FL - 1));
    check("a5_valid", cv, (32'(1) << FL) - 1);
    check("a5_idle_after", 32'(outs()), 32'(6'b010001));

`ifndef PISO_PARITY_EN
    // Held valid: 01 then 80 stream back to back
    send(8'h01, 1'b1);
    din = 8'h80;
    start = acc_cnt;
    cq = '0; cv = '0; cr = '0;
    for (int i = 0; i < 16; i++) begin
      cq[i] = qout; cv[i] = sout_valid; cr[i] = din_ready;
      if (acc_cnt == start + 1) din_valid = 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("b2b_bits", cq, 32'h0000_8001);
    check("b2b_valid", cv, 32'h0000_FFFF);
    check("b2b_ready", cr, 32'h0000_8080);
    check("b2b_idle_after", 32'(outs()), 32'(6'b010001));
`endif

    // Asynchronous reset at bit 3 of FF
    send(8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'(6'b010001));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("no_resume", 32'(outs()), 32'(6'b010001));
    send(8'h0F, 1'b0);
    capture(FL, cq, cl, cv);
    check("post_reset_bits", cq, 32'h00F);
    check("post_reset_last", cl, 32'(1) << (FL - 1));

`ifdef PISO_PARITY_EN
    // Parity frame for 07: three ones -> parity 1
    send(8'h07, 1'b0);
    capture(FL, cq, cl, cv);
    check("parity_bits", cq, 32'h107);
    check("parity_last", cl, 32'h100);
`else
    // Valid raised mid-frame: waits for the last-bit edge, no gap
    send(8'h3C, 1'b0);
    start = acc_cnt;
    cq = '0; cv = '0; cr = '0;
    for (int i = 0; i < 16; i++) begin
      cq[i] = qout; cv[i] = sout_valid; cr[i] = din_ready;
      if (i == 4) begin
        din = 8'hC3;
        din_valid = 1'b1;
      end
      if (acc_cnt == start + 1) din_valid = 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("mid_bits", cq, 32'h0000_C33C);
    check("mid_valid", cv, 32'h0000_FFFF);
    check("mid_ready", cr, 32'h0000_8080);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 3) != 0);
      din = WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FL + 3) @(negedge clk);
    check("final_idle", 32'(outs()), 32'(6'b010001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
